apb_mst_arb: RTL
================

Name: apb_mst_arb

Overview:
- Round-robin arbiter and APB master sequencer that shares one APB bus between NREQ local requesters.
- Accepts one request per grant and drives the fixed two-phase APB transfer: SETUP, then ACCESS.
- Returns read data to the granted requester and drives the bus-side reset line.
- Sits between the block-level register clients and the APB master modport of the bus interface.

Parameters:
- NREQ, 4, number of requesters (2..16).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- pclk  input  1  bus clock.
- preset  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester request.
- req_ready  output  NREQ  one-hot acceptance pulse.
- req_addr  input  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  input  NREQ*DW  packed write data.
- req_write  input  NREQ  1 = write, 0 = read.
- rsp_valid  output  NREQ  one-hot completion pulse.
- rsp_rdata  output  DW  read data, shared by all requesters.
- paddr  output  AW  APB address.
- pwdata  output  DW  APB write data.
- pwrite  output  1  APB direction.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- presetn  output  1  APB reset, active-low.
- prdata  input  DW  APB read data.

Behaviour:
- All outputs are registered except req_ready, which is combinational from state, req_valid and the RR pointer.
- Reset values:
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, presetn = 0.
  - State = IDLE.
  - Last-grant pointer = NREQ-1, so requester 0 has first priority.
- presetn: asserted (0) asynchronously with preset; deasserts to 1 on the first pclk edge after preset falls.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration:
  - Occurs in IDLE, and in ACCESS for back-to-back transfers.
  - Search order is last+1, last+2, ... mod NREQ.
  - The first requester with req_valid = 1 wins.
  - req_ready[win] = 1 for that cycle only.
  - Winner's addr/wdata/write are latched into paddr/pwdata/pwrite; pointer is updated to win; next state is SETUP.
- IDLE with no req_valid: stay in IDLE; psel = 0, penable = 0; paddr/pwdata/pwrite hold their last values.
- SETUP: psel = 1, penable = 0. Next state is always ACCESS.
- ACCESS:
  - psel = 1, penable = 1. Transfer completes at the end of this cycle; there is no wait-state support.
  - prdata is captured at the end of ACCESS into rsp_rdata. For writes, rsp_rdata is loaded with 0.
  - rsp_valid[granted] pulses high for exactly one cycle, the cycle after ACCESS.
  - If any req_valid is set during ACCESS: arbitrate, pulse req_ready, next state SETUP (psel stays 1, penable drops to 0).
  - Otherwise: next state IDLE.
- Latency: from req_ready to rsp_valid is 3 cycles. Sustained throughput is one transfer per 2 cycles.
- req_valid deasserted before being granted: the request is simply not considered; no state change.
- Simultaneous requests: strict round-robin; each requester waits at most NREQ-1 transfers.
- Reset mid-transfer: the in-flight transfer is abandoned, no rsp_valid is issued, and the pointer returns to NREQ-1.
- req_* inputs are sampled only in the accepting cycle; they may change freely afterwards.

Optional Feature:
- Macro: APB_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock [NREQ].
  - If the winner has req_lock = 1 in its accepting cycle, the next arbitration considers only that requester.
  - Other requesters are stalled until that requester is accepted with req_lock = 0, or is not requesting at an arbitration point. Either case releases the lock and restores normal RR.
  - Reset clears the lock.
- When undefined: the port is absent and arbitration is pure RR.

Test Plan:
- Reset release: hold preset for 3 cycles, then drop it.
  -> All outputs are 0; presetn = 1 exactly one edge later; psel stays 0 while no requests.
- Single read: req_valid[2] = 1, addr = 0x0000_0010, write = 0, prdata = 0xDEAD_BEEF in ACCESS.
  -> req_ready[2] in cycle 0; SETUP in cycle 1; ACCESS in cycle 2; rsp_valid[2] = 1 with rsp_rdata = 0xDEAD_BEEF in cycle 3.
- Single write: req_valid[0], addr = 0x20, wdata = 0x1234_5678, write = 1.
  -> pwrite = 1 and pwdata = 0x1234_5678 through SETUP/ACCESS; rsp_valid[0] pulses with rsp_rdata = 0.
- All four requesters held valid continuously.
  -> Grant order 0,1,2,3,0; psel never drops; penable toggles 0,1 every cycle; each requester gets one transfer per 8 cycles.
- Assert preset during ACCESS of a transfer by requester 1.
  -> psel/penable go to 0 immediately; rsp_valid[1] never pulses; after release, requester 0 wins first.
- With APB_ARB_LOCK_EN: requester 3 issues 3 transfers with lock = 1, 1, 0 while requester 0 is also requesting.
  -> Grants 3,3,3, then 0.

Source files
------------

// File: rtl/apb_mst_arb.sv
// apb_mst_arb: round-robin arbiter that shares one APB master port between
// NREQ local requesters. Each accepted request runs a SETUP/ACCESS transfer.
// The response pulses on rsp_valid in the cycle after ACCESS.
// Back-to-back transfers are re-arbitrated in ACCESS, so one transfer
// completes every two cycles.
// Optional feature: define APB_ARB_LOCK_EN to add req_lock. A winner that
// holds req_lock keeps exclusive ownership of the next arbitration.
module apb_mst_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_write,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  output logic               pwrite,
  output logic               psel,
  output logic               penable,
  output logic               presetn,
  input  logic [DW-1:0]      prdata
`ifdef APB_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]    req_lock
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   last_q, last_d;     // last winner, also the in-flight owner
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            presetn_q;
`ifdef APB_ARB_LOCK_EN
  logic            lock_q, lock_d;
`endif

  logic            arb_en;   // this cycle is an arbitration point
  logic            rr_vld;
  logic [PW-1:0]   rr_win;
  logic [PW-1:0]   rr_idx;
  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic            accept;

  assign arb_en = (state_q == ST_IDLE) || (state_q == ST_ACCESS);
  assign accept = arb_en && win_vld;

  // Round-robin search starting one past the last winner, with optional lock override.
  always_comb begin
    rr_vld = 1'b0;
    rr_win = last_q;
    rr_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = PW'((int'(last_q) + k) % NREQ);
      if (!rr_vld && req_valid[rr_idx]) begin
        rr_vld = 1'b1;
        rr_win = rr_idx;
      end else begin
        rr_vld = rr_vld;
      end
    end
`ifdef APB_ARB_LOCK_EN
    if (lock_q && req_valid[last_q]) begin
      win_vld = 1'b1;
      win_idx = last_q;
    end else begin
      win_vld = rr_vld;
      win_idx = rr_win;
    end
`else
    win_vld = rr_vld;
    win_idx = rr_win;
`endif
  end

  // One-hot acceptance pulse, only at arbitration points.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and registered-output logic for the SETUP/ACCESS sequencer.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = accept ? ST_SETUP : ST_IDLE;
        psel_d  = accept;
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        rsp_valid_d[last_q] = 1'b1;
        rsp_rdata_d         = pwrite_q ? {DW{1'b0}} : prdata;
        state_d             = accept ? ST_SETUP : ST_IDLE;
        psel_d              = accept;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request fields are sampled only in the accepting cycle.
    if (accept) begin
      last_d   = win_idx;
      paddr_d  = req_addr[int'(win_idx)*AW +: AW];
      pwdata_d = req_wdata[int'(win_idx)*DW +: DW];
      pwrite_d = req_write[win_idx];
`ifdef APB_ARB_LOCK_EN
      lock_d   = req_lock[win_idx];
`endif
    end else begin
`ifdef APB_ARB_LOCK_EN
      // An arbitration point with nobody accepted releases any lock.
      lock_d   = arb_en ? 1'b0 : lock_q;
`else
      last_d   = last_q;
`endif
    end
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      last_q      <= PW'(NREQ - 1);
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef APB_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  // Bus reset: asserted asynchronously, released on the first edge after preset falls.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      presetn_q <= 1'b0;
    end else begin
      presetn_q <= 1'b1;
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign presetn   = presetn_q;

endmodule
